// File: rtl/flop_pipe_pkg.sv
// Shared constants and helpers for the flop_pipe_xor elastic register pipeline.
// MASK_DEFAULT doubles as the reset/flush value and the XOR whitening mask.
package flop_pipe_pkg;

  localparam int DEFAULT_WIDTH = 256;
  localparam logic [255:0] MASK_DEFAULT = {4{64'h0412_6424_0034_3C28}};

  // Widest valid vector popcount accepts; DEPTH must not exceed this.
  localparam int POP_MAX = 64;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/flop_pipe_xor_if.sv
// Upstream/downstream handshake bundle of flop_pipe_xor.
// The master drives beats in and consumes beats out; the slave is the pipe.
interface flop_pipe_xor_if #(
  parameter int WIDTH = flop_pipe_pkg::DEFAULT_WIDTH,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic             in_whiten;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_whiten, d, out_ready,
    input  in_ready, out_valid, q, occupancy
  );

  modport slave (
    input  in_valid, in_whiten, d, out_ready,
    output in_ready, out_valid, q, occupancy
  );

endinterface

// File: rtl/flop_pipe_stage.sv
// One pipeline slot: valid bit plus data register; data loads only on capture.
// Reset and clear return data to MASK; a simultaneous load and advance keeps the slot full.
module flop_pipe_stage #(
  parameter int               WIDTH = flop_pipe_pkg::DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] MASK  = WIDTH'(flop_pipe_pkg::MASK_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= 1'b0;
      dat <= MASK;
    end else if (clear) begin
      vld <= 1'b0;
      dat <= MASK;
    end else if (load) begin
      vld <= 1'b1;
      dat <= din;
    end else if (adv) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/flop_pipe_xor.sv
// Elastic DEPTH-stage valid/ready register pipe with optional XOR whitening, 1 beat/cycle.
// Define FLOP_PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module flop_pipe_xor
  import flop_pipe_pkg::*;
#(
  parameter int               WIDTH = DEFAULT_WIDTH,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] MASK  = WIDTH'(MASK_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  flop_pipe_xor_if.slave        bus
`ifdef FLOP_PIPE_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [WIDTH-1:0] din [DEPTH];
  logic             accept;
  logic [WIDTH-1:0] whitened;

  assign bus.in_ready = !reset && !clear && (!vld[0] || adv[0]);
  assign accept       = bus.in_valid && bus.in_ready;
  assign whitened     = bus.in_whiten ? (MASK ^ bus.d) : bus.d;

  // Advance ripples back from out_ready so bubbles collapse under a stall.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = vld[DEPTH-1] && bus.out_ready;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = vld[k] && (!vld[k+1] || adv[k+1]);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign load[k] = accept;
      assign din[k]  = whitened;
    end else begin : g_body
      assign load[k] = adv[k-1];
      assign din[k]  = dat[k-1];
    end

    flop_pipe_stage #(
      .WIDTH (WIDTH),
      .MASK  (MASK)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .load  (load[k]),
      .adv   (adv[k]),
      .din   (din[k]),
      .vld   (vld[k]),
      .dat   (dat[k])
    );
  end

  assign bus.out_valid = vld[DEPTH-1];
  assign bus.q         = dat[DEPTH-1];
  assign bus.occupancy = OCC_W'(popcount(POP_MAX'(vld)));

`ifdef FLOP_PIPE_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (clear) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flop_pipe_xor.sv
// Bench for flop_pipe_xor at DEPTH 2, 4 and 1 against a beat/position queue model.
// Also exercises stall_cnt when FLOP_PIPE_STALL_CNT_EN is defined.
module tb_flop_pipe_xor;

  localparam logic [255:0] MASK = {4{64'h0412_6424_0034_3C28}};
  localparam int DEP [3] = '{2, 4, 1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         iv   [3];
  logic         wh   [3];
  logic [255:0] dd   [3];
  logic         ordy [3];
  logic         clr  [3];
  logic         ov   [3];
  logic         ir   [3];
  logic [255:0] qq   [3];
  int           occ  [3];
`ifdef FLOP_PIPE_STALL_CNT_EN
  logic [31:0]  sc   [3];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  flop_pipe_xor_if #(.WIDTH(256), .DEPTH(2)) bus2 ();
  flop_pipe_xor_if #(.WIDTH(256), .DEPTH(4)) bus4 ();
  flop_pipe_xor_if #(.WIDTH(256), .DEPTH(1)) bus1 ();

  assign bus2.in_valid = iv[0]; assign bus2.in_whiten = wh[0];
  assign bus2.d = dd[0];        assign bus2.out_ready = ordy[0];
  assign bus4.in_valid = iv[1]; assign bus4.in_whiten = wh[1];
  assign bus4.d = dd[1];        assign bus4.out_ready = ordy[1];
  assign bus1.in_valid = iv[2]; assign bus1.in_whiten = wh[2];
  assign bus1.d = dd[2];        assign bus1.out_ready = ordy[2];

  assign ov[0] = bus2.out_valid; assign ir[0] = bus2.in_ready;
  assign qq[0] = bus2.q;         assign occ[0] = int'(bus2.occupancy);
  assign ov[1] = bus4.out_valid; assign ir[1] = bus4.in_ready;
  assign qq[1] = bus4.q;         assign occ[1] = int'(bus4.occupancy);
  assign ov[2] = bus1.out_valid; assign ir[2] = bus1.in_ready;
  assign qq[2] = bus1.q;         assign occ[2] = int'(bus1.occupancy);

  flop_pipe_xor #(.WIDTH(256), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .clear(clr[0]), .bus(bus2)
`ifdef FLOP_PIPE_STALL_CNT_EN
    , .stall_cnt(sc[0])
`endif
  );
  flop_pipe_xor #(.WIDTH(256), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .clear(clr[1]), .bus(bus4)
`ifdef FLOP_PIPE_STALL_CNT_EN
    , .stall_cnt(sc[1])
`endif
  );
  flop_pipe_xor #(.WIDTH(256), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .clear(clr[2]), .bus(bus1)
`ifdef FLOP_PIPE_STALL_CNT_EN
    , .stall_cnt(sc[2])
`endif
  );

  // Model: in-flight beats oldest first, each with its stage position.
  logic [255:0] mdat  [3][4];
  int           mpos  [3][4];
  int           mcnt  [3];
  bit           fresh [3];
  logic [31:0]  mst   [3];

  task automatic chk(input string nm, input int i, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  function automatic logic [255:0] b(input int v);
    return {224'd0, 32'(v)};
  endfunction

  task automatic step(input int i);
    int dep, n, lim, m;
    int np [4];
    bit e_ov, e_ir;
    dep = DEP[i];
    n   = mcnt[i];
    if (reset) begin
      mcnt[i] = 0; fresh[i] = 1'b1; mst[i] = '0;
      chk("rst_out_valid", i, b(int'(ov[i])), b(0));
      chk("rst_in_ready", i, b(int'(ir[i])), b(0));
      chk("rst_occupancy", i, b(occ[i]), b(0));
      chk("rst_q", i, qq[i], MASK);
`ifdef FLOP_PIPE_STALL_CNT_EN
      chk("rst_stall_cnt", i, {224'd0, sc[i]}, b(0));
`endif
      return;
    end
    // Each beat moves one step unless blocked by the beat ahead; the head leaves on out_ready.
    lim = ordy[i] ? dep : dep - 1;
    for (int k = 0; k < n; k++) begin
      np[k] = (mpos[i][k] + 1 < lim) ? mpos[i][k] + 1 : lim;
      lim   = np[k] - 1;
    end
    e_ov = (n > 0) && (mpos[i][0] == dep - 1);
    e_ir = !clr[i] && ((n == 0) || (np[n-1] >= 1));
    chk("out_valid", i, b(int'(ov[i])), b(int'(e_ov)));
    chk("in_ready", i, b(int'(ir[i])), b(int'(e_ir)));
    chk("occupancy", i, b(occ[i]), b(n));
    if (e_ov) chk("q", i, qq[i], mdat[i][0]);
    else if (fresh[i]) chk("q_flushed", i, qq[i], MASK);
`ifdef FLOP_PIPE_STALL_CNT_EN
    chk("stall_cnt", i, {224'd0, sc[i]}, {224'd0, mst[i]});
`endif
    if (clr[i]) begin
      mcnt[i] = 0; fresh[i] = 1'b1; mst[i] = '0;
      return;
    end
    if (e_ov && !ordy[i] && (mst[i] != 32'hFFFF_FFFF)) mst[i] = mst[i] + 32'd1;
    m = 0;
    for (int k = 0; k < n; k++) begin
      if (np[k] < dep) begin
        if (np[k] == dep - 1 && mpos[i][k] != dep - 1) fresh[i] = 1'b0;
        mpos[i][m] = np[k];
        mdat[i][m] = mdat[i][k];
        m++;
      end
    end
    if (iv[i] && e_ir) begin
      mpos[i][m] = 0;
      mdat[i][m] = wh[i] ? (MASK ^ dd[i]) : dd[i];
      if (dep == 1) fresh[i] = 1'b0;
      m++;
    end
    mcnt[i] = m;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) step(i);
  end

  task automatic fill(input int i, input int base, input int n);
    ordy[i] = 1'b0; iv[i] = 1'b1; wh[i] = 1'b0;
    for (int k = 0; k < n; k++) begin
      dd[i] = b(base + k);
      @(posedge clk); #1;
    end
    iv[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 0; wh[i] = 0; dd[i] = '0; ordy[i] = 0; clr[i] = 0;
      mcnt[i] = 0; fresh[i] = 1; mst[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Streaming through DEPTH 2.
    ordy[0] = 1; iv[0] = 1; dd[0] = b(1);
    @(posedge clk); #1 dd[0] = b(2);
    @(posedge clk); #1 dd[0] = b(3);
    chk("stream_q1", 0, qq[0], b(1));
    @(posedge clk); #1 iv[0] = 0;
    chk("stream_q2", 0, qq[0], b(2));
    @(posedge clk); #1;
    chk("stream_q3", 0, qq[0], b(3));
    chk("stream_ov3", 0, b(int'(ov[0])), b(1));
    @(posedge clk); #1;
    chk("stream_drained", 0, b(int'(ov[0])), b(0));

    // Whitening.
    iv[0] = 1; wh[0] = 1; dd[0] = MASK;
    @(posedge clk); #1 dd[0] = '0;
    @(posedge clk); #1 iv[0] = 0; wh[0] = 0;
    chk("whiten_mask", 0, qq[0], '0);
    @(posedge clk); #1;
    chk("whiten_zero", 0, qq[0], MASK);

    // Backpressure on DEPTH 4: fifth beat waits, then enters as the first drains.
    fill(1, 101, 4);
    iv[1] = 1; dd[1] = b(105);
    chk("bp_in_ready", 1, b(int'(ir[1])), b(0));
    chk("bp_occ_full", 1, b(occ[1]), b(4));
    @(posedge clk); #1;
    chk("bp_hold_q", 1, qq[1], b(101));
    chk("bp_hold_occ", 1, b(occ[1]), b(4));
    ordy[1] = 1; #1;
    chk("bp_ready_comb", 1, b(int'(ir[1])), b(1));
    @(posedge clk); #1 iv[1] = 0;
    chk("bp_shift_occ", 1, b(occ[1]), b(4));
    for (int k = 102; k <= 105; k++) begin
      chk("bp_drain_q", 1, qq[1], b(k));
      @(posedge clk); #1;
    end
    chk("bp_empty", 1, b(occ[1]), b(0));

    // Clear while full with a beat offered.
    fill(1, 201, 4);
    clr[1] = 1; iv[1] = 1; dd[1] = b(205); #1;
    chk("clr_in_ready", 1, b(int'(ir[1])), b(0));
    chk("clr_q_shown", 1, qq[1], b(201));
    @(posedge clk); #1 clr[1] = 0; iv[1] = 0;
    chk("clr_occ", 1, b(occ[1]), b(0));
    chk("clr_ov", 1, b(int'(ov[1])), b(0));
    chk("clr_q", 1, qq[1], MASK);

`ifdef FLOP_PIPE_STALL_CNT_EN
    begin
      logic [31:0] s0;
      fill(1, 301, 4);
      s0 = sc[1];
      repeat (10) @(posedge clk);
      #1;
      chk("stall_10", 1, {224'd0, sc[1]}, {224'd0, s0 + 32'd10});
      clr[1] = 1;
      @(posedge clk); #1 clr[1] = 0;
      chk("stall_clr", 1, {224'd0, sc[1]}, b(0));
    end
`endif

    // DEPTH 1: ready follows out_ready when full.
    fill(2, 401, 1);
    chk("d1_full_rdy", 2, b(int'(ir[2])), b(0));
    chk("d1_full_q", 2, qq[2], b(401));
    ordy[2] = 1; #1;
    chk("d1_pass_rdy", 2, b(int'(ir[2])), b(1));
    iv[2] = 1; dd[2] = b(402);
    @(posedge clk); #1 iv[2] = 0;
    chk("d1_swap_q", 2, qq[2], b(402));
    chk("d1_swap_occ", 2, b(occ[2]), b(1));

    // Random traffic on all three pipes.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        iv[i]   = ($urandom_range(0, 3) != 0);
        wh[i]   = $urandom_range(0, 1) == 1;
        ordy[i] = ($urandom_range(0, 9) < 6);
        clr[i]  = ($urandom_range(0, 31) == 0);
        for (int w = 0; w < 8; w++) dd[i][w*32 +: 32] = $urandom;
      end
    end

    // Async reset mid-cycle with beats in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1; ordy[i] = 0; clr[i] = 0; dd[i] = b(500 + i);
    end
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("arst_ov", i, b(int'(ov[i])), b(0));
      chk("arst_occ", i, b(occ[i]), b(0));
      chk("arst_q", i, qq[i], MASK);
      iv[i] = 0;
    end
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
